// File: rtl/hazard_ctrl_v2_if.sv
// Hazard-controller bundle: pipeline-side register/control info in, stall/flush/forward out.
// master = pipeline stages, slave = hazard controller.
interface hazard_ctrl_v2_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] Rs1B;
    logic [REG_ADDR_W-1:0] Rs2B;
    logic [REG_ADDR_W-1:0] Rs1C;
    logic [REG_ADDR_W-1:0] Rs2C;
    logic [REG_ADDR_W-1:0] RdC;
    logic                  RegWriteC;
    logic [1:0]            ResultSrcC;
    logic [REG_ADDR_W-1:0] RdD;
    logic                  RegWriteD;
    logic                  MemReqD;
    logic [REG_ADDR_W-1:0] RdE;
    logic                  RegWriteE;
    logic                  PCSrcA;

    logic [1:0]            ForwardAH;
    logic [1:0]            ForwardBH;
    logic                  StallA;
    logic                  StallB;
    logic                  StallC;
    logic                  StallD;
    logic                  FlushB;
    logic                  FlushC;
    logic                  FlushE;
    logic [CNT_W-1:0]      StallCnt;
    logic [CNT_W-1:0]      FlushCnt;

    modport master (
        output Rs1B, Rs2B, Rs1C, Rs2C, RdC, RegWriteC, ResultSrcC,
        output RdD, RegWriteD, MemReqD, RdE, RegWriteE, PCSrcA,
        input  ForwardAH, ForwardBH, StallA, StallB, StallC, StallD,
        input  FlushB, FlushC, FlushE, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1B, Rs2B, Rs1C, Rs2C, RdC, RegWriteC, ResultSrcC,
        input  RdD, RegWriteD, MemReqD, RdE, RegWriteE, PCSrcA,
        output ForwardAH, ForwardBH, StallA, StallB, StallC, StallD,
        output FlushB, FlushC, FlushE, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl_v2.sv
// Five-stage pipeline hazard controller: D/E forwarding, load-use / RAW stalls, redirect
// flushes, multi-cycle data-memory freeze FSM and saturating stall/flush counters.
module hazard_ctrl_v2 #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned FWD_EN      = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_v2_if.slave  hz_io
);

    if (CNT_W == 0 || CNT_W > DATA_WIDTH) begin : g_bad_cnt_w
        $error("hazard_ctrl_v2: CNT_W must be in 1..DATA_WIDTH");
    end

    // WAIT covers latency cycles 2..MEM_LATENCY, so the counter only needs MEM_LATENCY-2.
    localparam int unsigned   WaitW    = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [WaitW-1:0] WaitLoad = (MEM_LATENCY > 1) ? WaitW'(MEM_LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       mem_freeze;
    logic       lu;
    logic       raw;
    logic       hazard;
    logic       redirect;
    logic       stall_ab;
    logic       stall_cd;
    logic       flush_b;
    logic       flush_c;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    function automatic logic dep(input logic [REG_ADDR_W-1:0] rs,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic                  we);
        return we && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic [REG_ADDR_W-1:0] rd_d,
                                           input logic                  we_d,
                                           input logic [REG_ADDR_W-1:0] rd_e,
                                           input logic                  we_e);
        if (dep(rs, rd_d, we_d)) begin
            return 2'b10;
        end else if (dep(rs, rd_e, we_e)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Memory wait FSM
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_freeze = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hz_io.MemReqD && (MEM_LATENCY > 0)) begin
                    mem_freeze = 1'b1;
                    if (MEM_LATENCY == 1) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                        wait_d  = WaitLoad;
                    end
                end
            end
            StWait: begin
                mem_freeze = 1'b1;
                if (wait_q == '0) begin
                    state_d = StDone;
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            // Same memory instruction still in D: ignore its request for one cycle.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign lu = hz_io.RegWriteC && (hz_io.ResultSrcC == 2'b01) &&
                (dep(hz_io.Rs1B, hz_io.RdC, 1'b1) || dep(hz_io.Rs2B, hz_io.RdC, 1'b1));

    assign raw = dep(hz_io.Rs1B, hz_io.RdC, hz_io.RegWriteC) ||
                 dep(hz_io.Rs1B, hz_io.RdD, hz_io.RegWriteD) ||
                 dep(hz_io.Rs1B, hz_io.RdE, hz_io.RegWriteE) ||
                 dep(hz_io.Rs2B, hz_io.RdC, hz_io.RegWriteC) ||
                 dep(hz_io.Rs2B, hz_io.RdD, hz_io.RegWriteD) ||
                 dep(hz_io.Rs2B, hz_io.RdE, hz_io.RegWriteE);

    assign hazard = (FWD_EN != 0) ? lu : raw;

    // Priority: freeze > redirect > lu/raw. Everything is quiet while rst is high.
    always_comb begin
        redirect = 1'b0;
        stall_ab = 1'b0;
        stall_cd = 1'b0;
        flush_b  = 1'b0;
        flush_c  = 1'b0;
        flush_e  = 1'b0;
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;
        if (!rst) begin
            if (mem_freeze) begin
                stall_ab = 1'b1;
                stall_cd = 1'b1;
                flush_e  = 1'b1;
            end else if (hz_io.PCSrcA) begin
                redirect = 1'b1;
                flush_b  = 1'b1;
                flush_c  = 1'b1;
            end else if (hazard) begin
                stall_ab = 1'b1;
                flush_c  = 1'b1;
            end
            if (FWD_EN != 0) begin
                fwd_a = fwd_sel(hz_io.Rs1C, hz_io.RdD, hz_io.RegWriteD, hz_io.RdE,
                                hz_io.RegWriteE);
                fwd_b = fwd_sel(hz_io.Rs2C, hz_io.RdD, hz_io.RegWriteD, hz_io.RdE,
                                hz_io.RegWriteE);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ab && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_io.ForwardAH = fwd_a;
    assign hz_io.ForwardBH = fwd_b;
    assign hz_io.StallA    = stall_ab;
    assign hz_io.StallB    = stall_ab;
    assign hz_io.StallC    = stall_cd;
    assign hz_io.StallD    = stall_cd;
    assign hz_io.FlushB    = flush_b;
    assign hz_io.FlushC    = flush_c;
    assign hz_io.FlushE    = flush_e;
    assign hz_io.StallCnt  = stall_cnt_q;
    assign hz_io.FlushCnt  = flush_cnt_q;

endmodule
